ex_fwd_unit: RTL and testbench

Parametrised EX-stage operand forwarding and hazard block for the rv32 core. It resolves NSRC source operands against in-flight EX/MEM and MEM/WB results and detects load-use hazards. It inserts a one-cycle bubble on a load-use hazard and registers the resolved operands into the EX operand register with a valid/ready handshake.

---
 rtl/ex_fwd_unit_if.sv | 43 ++++
 rtl/ex_fwd_unit.sv | 138 +++++++++++++
 tb/tb_ex_fwd_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_fwd_unit_if.sv
// ex_fwd_unit_if: ID/pipeline operand bus for the EX forwarding unit.
// master drives ID and pipeline state, slave returns resolved operands.
interface ex_fwd_unit_if #(
   parameter int XLEN = 32,
   parameter int NSRC = 2,
   parameter int REGW = 5
);
   logic                 id_valid;
   logic [NSRC*REGW-1:0] id_rs;
   logic [NSRC*XLEN-1:0] id_rdata;
   logic [REGW-1:0]      ex_rd;
   logic                 ex_regwrite;
   logic                 ex_memread;
   logic [REGW-1:0]      mem_rd;
   logic                 mem_regwrite;
   logic [XLEN-1:0]      mem_data;
   logic [REGW-1:0]      wb_rd;
   logic                 wb_regwrite;
   logic [XLEN-1:0]      wb_data;
   logic                 ex_ready;
   logic                 stall_o;
   logic                 op_valid;
   logic [NSRC*XLEN-1:0] op_data;
   logic [NSRC*2-1:0]    fwd_sel;

   modport master (
      output id_valid, id_rs, id_rdata,
      output ex_rd, ex_regwrite, ex_memread,
      output mem_rd, mem_regwrite, mem_data,
      output wb_rd, wb_regwrite, wb_data,
      output ex_ready,
      input  stall_o, op_valid, op_data, fwd_sel
   );

   modport slave (
      input  id_valid, id_rs, id_rdata,
      input  ex_rd, ex_regwrite, ex_memread,
      input  mem_rd, mem_regwrite, mem_data,
      input  wb_rd, wb_regwrite, wb_data,
      input  ex_ready,
      output stall_o, op_valid, op_data, fwd_sel
   );
endinterface

// File: rtl/ex_fwd_unit.sv
// ex_fwd_unit: EX operand forwarding, load-use bubble and operand register.
// Optional macro FWD_STATS_EN adds saturating forward/stall counters.
module ex_fwd_unit #(
   parameter int XLEN = 32,
   parameter int NSRC = 2,
   parameter int REGW = 5
) (
   input  logic         clk,
   input  logic         rst,
`ifdef FWD_STATS_EN
   output logic [31:0]  stat_fwd_cnt,
   output logic [31:0]  stat_stall_cnt,
`endif
   ex_fwd_unit_if.slave bus
);

   typedef enum logic {RUN, LU_WAIT} state_t;

   state_t               state_q, state_d;
   logic                 valid_q, valid_d;
   logic [NSRC*XLEN-1:0] data_q, data_d;
   logic [NSRC*2-1:0]    sel_q, sel_d;

   logic [NSRC*XLEN-1:0] res;
   logic [NSRC*2-1:0]    sel;
   logic                 lu_cand;
   logic                 lu_hit;
   logic                 stall;
   logic                 bp, lu, acc, idle;

   always_comb begin
      res     = bus.id_rdata;
      sel     = '0;
      lu_cand = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         logic mem_hit, wb_hit;
         mem_hit = bus.mem_regwrite && (bus.mem_rd != '0) &&
                   (bus.mem_rd == bus.id_rs[i*REGW +: REGW]);
         wb_hit  = !mem_hit && bus.wb_regwrite && (bus.wb_rd != '0) &&
                   (bus.wb_rd == bus.id_rs[i*REGW +: REGW]);
         unique case (1'b1)
            mem_hit: begin
               res[i*XLEN +: XLEN] = bus.mem_data;
               sel[i*2 +: 2]       = 2'b10;
            end
            wb_hit: begin
               res[i*XLEN +: XLEN] = bus.wb_data;
               sel[i*2 +: 2]       = 2'b01;
            end
            default: ;
         endcase
         if (bus.id_rs[i*REGW +: REGW] == bus.ex_rd)
            lu_cand = 1'b1;
      end
      lu_hit = bus.id_valid && bus.ex_memread && bus.ex_regwrite &&
               (bus.ex_rd != '0) && lu_cand;
   end

   // Backpressure outranks the hazard; LU_WAIT ignores the hazard.
   assign bp   = !bus.ex_ready;
   assign lu   = bus.ex_ready && (state_q == RUN) && lu_hit;
   assign acc  = bus.ex_ready && bus.id_valid && !((state_q == RUN) && lu_hit);
   assign idle = bus.ex_ready && !bus.id_valid;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      stall   = 1'b0;
      unique case (1'b1)
         bp: stall = bus.id_valid;
         lu: begin
            stall   = 1'b1;
            valid_d = 1'b0;
            state_d = LU_WAIT;
         end
         acc: begin
            valid_d = 1'b1;
            data_d  = res;
            sel_d   = sel;
            state_d = RUN;
         end
         idle: begin
            valid_d = 1'b0;
            state_d = RUN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   assign bus.stall_o  = stall && !rst;
   assign bus.op_valid = valid_q;
   assign bus.op_data  = data_q;
   assign bus.fwd_sel  = sel_q;

`ifdef FWD_STATS_EN
   logic [31:0] fwd_n;
   logic [32:0] fwd_sum;
   logic [32:0] stall_sum;

   always_comb begin
      fwd_n = '0;
      for (int i = 0; i < NSRC; i++)
         if (sel[i*2 +: 2] != 2'b00)
            fwd_n = fwd_n + 32'd1;
      fwd_sum   = {1'b0, stat_fwd_cnt} + {1'b0, fwd_n};
      stall_sum = {1'b0, stat_stall_cnt} + 33'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_fwd_cnt   <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (acc)
            stat_fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
         if (stall)
            stat_stall_cnt <= stall_sum[32] ? '1 : stall_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_ex_fwd_unit.sv
// tb_ex_fwd_unit: directed checks of forwarding, load-use and backpressure.
// Define FWD_STATS_EN to also check the statistics counters.
module tb_ex_fwd_unit;
   localparam int XLEN = 32;
   localparam int NSRC = 2;
   localparam int REGW = 5;

   logic clk = 1'b0;
   logic rst;
   int   ncmp = 0;
   int   nfail = 0;

   ex_fwd_unit_if #(.XLEN(XLEN), .NSRC(NSRC), .REGW(REGW)) bus ();

`ifdef FWD_STATS_EN
   logic [31:0] sfwd, sstall;
`endif

   ex_fwd_unit #(.XLEN(XLEN), .NSRC(NSRC), .REGW(REGW)) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef FWD_STATS_EN
      .stat_fwd_cnt   (sfwd),
      .stat_stall_cnt (sstall),
`endif
      .bus            (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      bus.id_valid     = 1'b0;
      bus.id_rs        = '0;
      bus.id_rdata     = '0;
      bus.ex_rd        = '0;
      bus.ex_regwrite  = 1'b0;
      bus.ex_memread   = 1'b0;
      bus.mem_rd       = '0;
      bus.mem_regwrite = 1'b0;
      bus.mem_data     = '0;
      bus.wb_rd        = '0;
      bus.wb_regwrite  = 1'b0;
      bus.wb_data      = '0;
      bus.ex_ready     = 1'b1;
   endtask

   task automatic s2;
      clr();
      bus.id_valid     = 1'b1;
      bus.id_rs        = {5'd3, 5'd4};
      bus.id_rdata     = {32'h22, 32'h11};
      bus.mem_rd       = 5'd4;
      bus.mem_regwrite = 1'b1;
      bus.mem_data     = 32'hAAAA;
      bus.wb_rd        = 5'd4;
      bus.wb_regwrite  = 1'b1;
      bus.wb_data      = 32'hBBBB;
      tick();
      chk("s2_mem_valid", 64'(bus.op_valid), 64'd1);
      chk("s2_mem_data", bus.op_data, {32'h22, 32'hAAAA});
      chk("s2_mem_sel", 64'(bus.fwd_sel), 64'b0010);
      bus.mem_regwrite = 1'b0;
      tick();
      chk("s2_wb_data", bus.op_data, {32'h22, 32'hBBBB});
      chk("s2_wb_sel", 64'(bus.fwd_sel), 64'b0001);
   endtask

   task automatic s4(input logic [63:0] held);
      clr();
      bus.id_valid    = 1'b1;
      bus.ex_memread  = 1'b1;
      bus.ex_regwrite = 1'b1;
      bus.ex_rd       = 5'd7;
      bus.id_rs       = {5'd7, 5'd3};
      bus.id_rdata    = {32'h99, 32'h11};
      #1;
      chk("s4_stall", 64'(bus.stall_o), 64'd1);
      tick();
      chk("s4_bubble", 64'(bus.op_valid), 64'd0);
      chk("s4_bubble_hold", bus.op_data, held);
      bus.ex_memread   = 1'b0;
      bus.ex_regwrite  = 1'b0;
      bus.ex_rd        = '0;
      bus.mem_rd       = 5'd7;
      bus.mem_regwrite = 1'b1;
      bus.mem_data     = 32'h1234;
      #1;
      chk("s4_wait_stall", 64'(bus.stall_o), 64'd0);
      tick();
      chk("s4_valid", 64'(bus.op_valid), 64'd1);
      chk("s4_data", bus.op_data, {32'h1234, 32'h11});
      chk("s4_sel", 64'(bus.fwd_sel), 64'b1000);
   endtask

   initial begin
      clr();
      rst             = 1'b1;
      bus.id_valid    = 1'b1;
      bus.ex_memread  = 1'b1;
      bus.ex_regwrite = 1'b1;
      bus.ex_rd       = 5'd7;
      bus.id_rs       = {5'd7, 5'd7};
      #12;
      chk("rst_valid", 64'(bus.op_valid), 64'd0);
      chk("rst_data", bus.op_data, 64'd0);
      chk("rst_sel", 64'(bus.fwd_sel), 64'd0);
      chk("rst_stall", 64'(bus.stall_o), 64'd0);
      clr();
      rst = 1'b0;

      // no hazards
      bus.id_valid = 1'b1;
      bus.id_rs    = {5'd4, 5'd3};
      bus.id_rdata = {32'h22, 32'h11};
      #1;
      chk("s1_stall", 64'(bus.stall_o), 64'd0);
      tick();
      chk("s1_valid", 64'(bus.op_valid), 64'd1);
      chk("s1_data", bus.op_data, {32'h22, 32'h11});
      chk("s1_sel", 64'(bus.fwd_sel), 64'd0);

      s2();

      // x0 never forwards
      clr();
      bus.id_valid     = 1'b1;
      bus.id_rs        = {5'd3, 5'd0};
      bus.id_rdata     = {32'h22, 32'h55};
      bus.mem_rd       = 5'd0;
      bus.mem_regwrite = 1'b1;
      bus.mem_data     = 32'hDEAD;
      tick();
      chk("s3_data", bus.op_data, {32'h22, 32'h55});
      chk("s3_sel", 64'(bus.fwd_sel), 64'd0);

      s4({32'h22, 32'h55});

      clr();
      tick();
      chk("idle_valid", 64'(bus.op_valid), 64'd0);
      chk("idle_hold", bus.op_data, {32'h1234, 32'h11});

      // backpressure during load-use
      bus.id_valid = 1'b1;
      bus.id_rs    = {5'd3, 5'd3};
      bus.id_rdata = {32'h66, 32'h77};
      tick();
      chk("s5_pre_valid", 64'(bus.op_valid), 64'd1);
      bus.ex_memread  = 1'b1;
      bus.ex_regwrite = 1'b1;
      bus.ex_rd       = 5'd7;
      bus.id_rs       = {5'd7, 5'd3};
      bus.ex_ready    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("s5_bp_stall", 64'(bus.stall_o), 64'd1);
         tick();
         chk("s5_bp_valid", 64'(bus.op_valid), 64'd1);
         chk("s5_bp_data", bus.op_data, {32'h66, 32'h77});
      end
      bus.ex_ready = 1'b1;
      #1;
      chk("s5_lu_stall", 64'(bus.stall_o), 64'd1);
      tick();
      chk("s5_bubble", 64'(bus.op_valid), 64'd0);
      chk("s5_bubble_data", bus.op_data, {32'h66, 32'h77});
      bus.ex_ready = 1'b0;
      #1;
      chk("s5_wait_bp_stall", 64'(bus.stall_o), 64'd1);
      tick();
      chk("s5_wait_bp_valid", 64'(bus.op_valid), 64'd0);
      rst = 1'b1;
      #1;
      chk("s5_rst_valid", 64'(bus.op_valid), 64'd0);
      chk("s5_rst_data", bus.op_data, 64'd0);
      chk("s5_rst_stall", 64'(bus.stall_o), 64'd0);
      #1;
      rst          = 1'b0;
      bus.ex_ready = 1'b1;
      #1;
      chk("s5_run_stall", 64'(bus.stall_o), 64'd1);
      tick();
      chk("s5_rerun_bubble", 64'(bus.op_valid), 64'd0);
      bus.ex_memread   = 1'b0;
      bus.ex_regwrite  = 1'b0;
      bus.mem_rd       = 5'd7;
      bus.mem_regwrite = 1'b1;
      bus.mem_data     = 32'h5678;
      tick();
      chk("s5_acc_valid", 64'(bus.op_valid), 64'd1);
      chk("s5_acc_data", bus.op_data, {32'h5678, 32'h77});
      chk("s5_acc_sel", 64'(bus.fwd_sel), 64'b1000);

      clr();
      bus.ex_ready = 1'b0;
      #1;
      chk("bp_idle_stall", 64'(bus.stall_o), 64'd0);
      tick();

`ifdef FWD_STATS_EN
      clr();
      rst = 1'b1;
      #2;
      chk("st_rst_fwd", 64'(sfwd), 64'd0);
      rst = 1'b0;
      tick();
      s2();
      s4({32'h22, 32'hBBBB});
      chk("st_fwd", 64'(sfwd), 64'd3);
      chk("st_stall", 64'(sstall), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
